// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with per-stage flush and bubble collapsing.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush,
    output logic [CW-1:0]    occupancy,
    output logic [31:0]      stall_cnt
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] pv;
    logic [DEPTH-1:0] nv;
    logic [WIDTH-1:0] d  [DEPTH];
    logic [WIDTH-1:0] pd [DEPTH];
    logic [CW-1:0]    next_occ;

    // Predecessor view: stage 0 sees the input port, stage i sees stage i-1.
    generate
        if (DEPTH > 1) begin : g_pv_multi
            assign pv = {v[DEPTH-2:0], in_valid};
        end else begin : g_pv_single
            assign pv = in_valid;
        end
        for (genvar g = 0; g < DEPTH; g++) begin : g_pd
            if (g == 0) begin : g_first
                assign pd[g] = in_data;
            end else begin : g_rest
                assign pd[g] = d[g-1];
            end
        end
    endgenerate

    // A stage can accept if the output drains or any stage at or after it is empty.
    always_comb begin
        logic acc;
        r   = '0;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc  = acc | ~v[i];
            r[i] = acc;
        end
    end

    always_comb begin
        nv       = '0;
        next_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nv[i]    = flush[i] ? 1'b0 : (r[i] ? pv[i] : v[i]);
            next_occ = next_occ + CW'(nv[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            v         <= nv;
            occupancy <= next_occ;
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i] && pv[i]) begin
                    d[i] <= pd[i];
                end
            end
        end
    end

    assign in_ready  = r[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where the output is blocked downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (v[DEPTH-1] && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
